uart_tx_arbiter: RTL and testbench

- Shares the single UART transmit path (write / write_data / tx_fifo_full) among NUM_REQ requesters.
- Arbitration is round-robin at frame granularity: once a requester wins, it owns the UART until it sends its last byte or stalls past a timeout.
- Sits between on-chip message sources (test engines, status reporters, CPU shim) and the UART block.
- Paces writes so the UART's registered FIFO-full flag is always current when a write is issued.

---
 rtl/uart_tx_arbiter_if.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and UART-side handshake bundle for uart_tx_arbiter
//
// Purpose: groups the per-requester byte streams and the UART write port.
// Signals:
//   req_valid / req_data / req_last  requester -> arbiter, one lane per requester
//   req_ready                        arbiter -> requester, byte taken when valid&ready
//   uart_write / uart_write_data     arbiter -> UART, one-cycle write strobe and byte
//   uart_tx_fifo_full                UART -> arbiter, registered FIFO-full flag
// Modports: master = environment side (requesters + UART), slave = arbiter side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int PAYLOAD_BITS = 8
);
  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]              req_last;
  logic [NUM_REQ-1:0]              req_ready;
  logic                            uart_write;
  logic [PAYLOAD_BITS-1:0]         uart_write_data;
  logic                            uart_tx_fifo_full;

  modport master (
    output req_valid, req_data, req_last, uart_tx_fifo_full,
    input  req_ready, uart_write, uart_write_data
  );

  modport slave (
    input  req_valid, req_data, req_last, uart_tx_fifo_full,
    output req_ready, uart_write, uart_write_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - frame-granular round-robin arbiter for a shared UART TX path
//
// Purpose: lets NUM_REQ byte sources share one UART write port. A requester that
// wins keeps the UART until its last byte is accepted or it stays silent for
// TIMEOUT_CYCLES cycles. Writes are spaced so the UART's registered full flag has
// caught up before the next byte is accepted.
// Ports:
//   clk, resetn   clock and synchronous active-low reset
//   bus           uart_tx_arbiter_if.slave (requester lanes + UART write port)
//   busy          high while a requester owns the UART
//   owner         current or most recent owner index
//   abort_pulse   one-cycle pulse when an owner is released by the timeout
//   abort_id      requester released by the timeout
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int PAYLOAD_BITS   = 8,
  parameter int WRITE_GAP      = 1,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic            clk,
  input  logic            resetn,
  uart_tx_arbiter_if.slave bus,
  output logic            busy,
  output logic [OW-1:0]   owner,
  output logic            abort_pulse,
  output logic [OW-1:0]   abort_id
);

  localparam int GW = (WRITE_GAP > 0) ? $clog2(WRITE_GAP + 1) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [0:0]    STATE_IDLE   = 1'b0;
  localparam logic [0:0]    STATE_LOCKED = 1'b1;
  localparam logic [GW-1:0] GAP_LOAD     = GW'(WRITE_GAP);
  localparam logic [TW-1:0] TMO_LAST     = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [OW-1:0] LAST_IDX     = OW'(NUM_REQ - 1);

  logic [0:0]              state_q, state_d;
  logic [OW-1:0]           owner_q, owner_d;
  logic [OW-1:0]           ptr_q, ptr_d;
  logic [GW-1:0]           gap_q, gap_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic                    write_q, write_d;
  logic [PAYLOAD_BITS-1:0] wdata_q, wdata_d;
  logic                    abort_q, abort_d;
  logic [OW-1:0]           abort_id_q, abort_id_d;

  logic                    gap_ok;
  logic                    locked;
  logic                    owner_valid;
  logic                    owner_last;
  logic [PAYLOAD_BITS-1:0] owner_data;
  logic [OW-1:0]           owner_next;
  logic                    accept;
  logic                    tmo_hit;
  logic [NUM_REQ-1:0]      ready_vec;
  logic                    grant_found;
  logic [OW-1:0]           grant_idx;
  logic [OW-1:0]           cand;

  assign locked      = (state_q == STATE_LOCKED);
  assign gap_ok      = (gap_q == '0);
  assign owner_valid = bus.req_valid[owner_q];
  assign owner_last  = bus.req_last[owner_q];
  assign owner_data  = bus.req_data[owner_q*PAYLOAD_BITS +: PAYLOAD_BITS];
  assign owner_next  = (owner_q == LAST_IDX) ? '0 : owner_q + OW'(1);
  assign accept      = locked & gap_ok & ~bus.uart_tx_fifo_full & owner_valid;
  // Only the owner's silence counts; a full-stalled owner keeps valid high and clears it.
  assign tmo_hit     = (TIMEOUT_CYCLES != 0) && !owner_valid && (tmo_q == TMO_LAST);

  always_comb begin
    ready_vec = '0;
    if (locked && gap_ok && !bus.uart_tx_fifo_full) begin
      ready_vec[owner_q] = 1'b1;
    end
  end

  assign bus.req_ready = ready_vec;

  // Scan from the pointer upward with wrap; walking k downward lets the
  // smallest offset overwrite the others, so the nearest valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = OW'((int'(ptr_q) + k) % NUM_REQ);
      if (bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    tmo_d      = tmo_q;
    write_d    = 1'b0;
    wdata_d    = wdata_q;
    abort_d    = 1'b0;
    abort_id_d = abort_id_q;
    gap_d      = gap_ok ? gap_q : gap_q - GW'(1);

    if (state_q == STATE_IDLE) begin
      if (grant_found) begin
        owner_d = grant_idx;
        state_d = STATE_LOCKED;
        tmo_d   = '0;
      end
    end else begin
      if (accept) begin
        write_d = 1'b1;
        wdata_d = owner_data;
        gap_d   = GAP_LOAD;
        tmo_d   = '0;
        if (owner_last) begin
          state_d = STATE_IDLE;
          ptr_d   = owner_next;
        end
      end else if (owner_valid) begin
        tmo_d = '0;
      end else if (tmo_hit) begin
        state_d    = STATE_IDLE;
        ptr_d      = owner_next;
        abort_d    = 1'b1;
        abort_id_d = owner_q;
        tmo_d      = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= STATE_IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      gap_q      <= '0;
      tmo_q      <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      abort_q    <= 1'b0;
      abort_id_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      gap_q      <= gap_d;
      tmo_q      <= tmo_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      abort_q    <= abort_d;
      abort_id_q <= abort_id_d;
    end
  end

  assign bus.uart_write      = write_q;
  assign bus.uart_write_data = wdata_q;
  assign busy                = locked;
  assign owner               = owner_q;
  assign abort_pulse         = abort_q;
  assign abort_id            = abort_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int PB = 8;
  localparam int WG = 1;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       busy;
  logic [1:0] owner;
  logic       abort_pulse;
  logic [1:0] abort_id;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .PAYLOAD_BITS(PB)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(NR), .PAYLOAD_BITS(PB), .WRITE_GAP(WG), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .busy(busy),
    .owner(owner), .abort_pulse(abort_pulse), .abort_id(abort_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [8:0] drv_q [NR][$];
  logic [8:0] mdl_q [NR][$];
  bit   mid [NR];
  int   hold_run [NR];

  bit mon_en = 0, rand_hold = 0, rand_full = 0, strict_gap = 0;
  int m_cur = -1, m_ptr = 0;
  bit m_first = 0;
  int last_wr_cyc = -100, wr_count = 0, abort_count = 0, abort_cyc = 0;
  bit prev_write = 0, prev_full = 0, s_abort = 0, any_acc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input int i, input logic [7:0] d, input logic last);
    drv_q[i].push_back({last, d});
    mdl_q[i].push_back({last, d});
  endtask

  function automatic int model_first(input int start);
    for (int k = 0; k < NR; k++) begin
      if (mdl_q[(start + k) % NR].size() > 0) return (start + k) % NR;
    end
    return -1;
  endfunction

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NR; i++) n += mdl_q[i].size();
    return n;
  endfunction

  // Transaction-level reference: bytes must leave in whole frames, frames in
  // round-robin order over requesters that still have data.
  task automatic monitor();
    logic [8:0] e;
    s_abort = abort_pulse;
    if (!mon_en) return;
    if (bus.uart_write) begin
      chk("no_back_to_back", 32'(prev_write), 0);
      chk("write_after_full", 32'(prev_full), 0);
      if (m_cur < 0) begin
        m_cur = model_first(m_ptr);
        m_first = 1;
      end
      chk("write_owner", 32'(owner), m_cur);
      if (m_cur >= 0 && mdl_q[m_cur].size() > 0) begin
        e = mdl_q[m_cur].pop_front();
        chk("write_data", 32'(bus.uart_write_data), 32'(e[7:0]));
        if (strict_gap && !m_first) chk("write_spacing", cyc - last_wr_cyc, WG + 1);
        else chk("write_spacing_min", 32'(cyc - last_wr_cyc >= WG + 1), 1);
        m_first = 0;
        if (e[8]) begin
          chk("busy_after_last", 32'(busy), 0);
          m_ptr = (m_cur + 1) % NR;
          m_cur = -1;
        end else begin
          chk("busy_mid_frame", 32'(busy), 1);
        end
      end else begin
        checks++;
        failures++;
        $error("FAIL write_unexpected observed=%0h expected=none", bus.uart_write_data);
      end
      last_wr_cyc = cyc;
      wr_count++;
    end
    if (abort_pulse) begin
      chk("abort_id", 32'(abort_id), m_cur);
      chk("abort_busy", 32'(busy), 0);
      if (m_cur >= 0) m_ptr = (m_cur + 1) % NR;
      m_cur = -1;
      abort_count++;
      abort_cyc = cyc;
    end
  endtask

  // One clock: drive at the negedge, check registered outputs, retire accepted bytes.
  task automatic step();
    logic [NR-1:0] v, acc;
    logic [8:0] tmp;
    bit hold;
    v = '0;
    for (int i = 0; i < NR; i++) begin
      hold = rand_hold && mid[i] && (hold_run[i] < 3) && ($urandom_range(0, 3) == 0);
      hold_run[i] = hold ? hold_run[i] + 1 : 0;
      if (drv_q[i].size() > 0) begin
        v[i] = !hold;
        bus.req_data[i*PB +: PB] = drv_q[i][0][7:0];
        bus.req_last[i] = drv_q[i][0][8];
      end else begin
        bus.req_data[i*PB +: PB] = '0;
        bus.req_last[i] = 1'b0;
      end
    end
    bus.req_valid = v;
    if (rand_full) bus.uart_tx_fifo_full = ($urandom_range(0, 2) == 0);
    #1;
    monitor();
    acc = bus.req_valid & bus.req_ready;
    prev_full = bus.uart_tx_fifo_full;
    prev_write = bus.uart_write;
    any_acc = (acc != '0);
    @(posedge clk);
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        tmp = drv_q[i].pop_front();
        mid[i] = !tmp[8];
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic reset_dut();
    resetn = 1'b0;
    mon_en = 0;
    rand_hold = 0;
    rand_full = 0;
    bus.uart_tx_fifo_full = 1'b0;
    for (int i = 0; i < NR; i++) begin
      drv_q[i].delete();
      mdl_q[i].delete();
      mid[i] = 0;
      hold_run[i] = 0;
    end
    repeat (3) step();
    chk("rst_uart_write", 32'(bus.uart_write), 0);
    chk("rst_write_data", 32'(bus.uart_write_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_abort", 32'(abort_pulse), 0);
    chk("rst_abort_id", 32'(abort_id), 0);
    chk("rst_ready", 32'(bus.req_ready), 0);
    resetn = 1'b1;
    m_cur = -1;
    m_ptr = 0;
    last_wr_cyc = -100;
    prev_write = 0;
    prev_full = 0;
    mon_en = 1;
  endtask

  task automatic drain(input int budget, input string tag);
    int n = 0;
    while (pending() > 0 && n < budget) begin
      step();
      n++;
    end
    repeat (4) step();
    chk(tag, pending(), 0);
  endtask

  initial begin
    int n, w, nf, len;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    bus.uart_tx_fifo_full = 1'b0;
    @(negedge clk);
    reset_dut();

    // Single requester 1, three bytes, writes exactly two cycles apart.
    strict_gap = 1;
    push_byte(1, 8'h41, 0);
    push_byte(1, 8'h42, 0);
    push_byte(1, 8'h43, 1);
    step();
    chk("t1_grant_busy", 32'(busy), 1);
    chk("t1_grant_owner", 32'(owner), 1);
    chk("t1_ready", 32'(bus.req_ready), 32'h2);
    drain(50, "t1_drain");
    // Pointer now 2: requester 2 goes before 0 and 1.
    push_byte(0, 8'hA0, 1);
    push_byte(1, 8'hB1, 1);
    push_byte(2, 8'hC2, 1);
    drain(60, "t1_ptr_drain");

    // Requesters 0 and 2 with two-byte frames from reset.
    reset_dut();
    push_byte(0, 8'h01, 0);
    push_byte(0, 8'h02, 1);
    push_byte(2, 8'h21, 0);
    push_byte(2, 8'h22, 1);
    drain(60, "t2_drain");

    // All four requesters, one-byte frames, eight frames.
    reset_dut();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++) push_byte(i, 8'(8'h30 + r*4 + i), 1);
    drain(100, "t3_drain");

    // FIFO full held for 20 cycles mid-frame.
    reset_dut();
    strict_gap = 0;
    push_byte(0, 8'h51, 0);
    push_byte(0, 8'h52, 0);
    push_byte(0, 8'h53, 1);
    n = 0;
    while (wr_count == 0 && n < 20) begin step(); n++; end
    w = wr_count;
    chk("t4_first_write_seen", 32'(w > 0), 1);
    bus.uart_tx_fifo_full = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("t4_hold_ready", 32'(bus.req_ready), 0);
      chk("t4_hold_write", 32'(bus.uart_write), 0);
      chk("t4_hold_abort", 32'(abort_pulse), 0);
    end
    bus.uart_tx_fifo_full = 1'b0;
    drain(50, "t4_drain");

    // Owner 1 goes silent after a non-last byte; timeout hands off to 2.
    reset_dut();
    push_byte(1, 8'h10, 0);
    push_byte(2, 8'h20, 1);
    n = 0;
    w = wr_count;
    while (wr_count == w && n < 20) begin step(); n++; end
    w = last_wr_cyc;
    n = 0;
    while (!s_abort && n < 40) begin step(); n++; end
    chk("t5_abort_seen", 32'(s_abort), 1);
    chk("t5_abort_delay", abort_cyc - w, TO);
    drain(50, "t5_drain");

    // Reset the cycle after a mid-frame accept.
    reset_dut();
    push_byte(3, 8'h61, 0);
    push_byte(3, 8'h62, 0);
    push_byte(3, 8'h63, 1);
    n = 0;
    any_acc = 0;
    while (!any_acc && n < 20) begin step(); n++; end
    chk("t6_accept_seen", 32'(any_acc), 1);
    reset_dut();
    push_byte(3, 8'h73, 1);
    push_byte(0, 8'h70, 1);
    drain(50, "t6_drain");

    // Random frames with owner pauses and FIFO-full noise.
    reset_dut();
    for (int i = 0; i < NR; i++) begin
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) begin
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) push_byte(i, 8'($urandom), b == len - 1);
      end
    end
    rand_hold = 1;
    rand_full = 1;
    drain(3000, "rand_drain");
    rand_hold = 0;
    rand_full = 0;
    bus.uart_tx_fifo_full = 1'b0;

    chk("abort_total", abort_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
